// File: rtl/coeff_fetch_seq.sv
// coeff_fetch_seq
// ---------------
// Coefficient ROM read sequencer for the piecewise-polynomial engine.
// When a segment index is accepted, it issues ORDER+1 reads, highest power
// first, so the Horner MAC sees the coefficients in the order it consumes them.
// A tag pipe that is MEM_LAT stages deep delays {valid, idx, last} by the
// memory latency. Its output therefore lines up with the read data.
//
// Ports
//   clkn_i        clock (rising edge active)
//   rst_i         asynchronous active-high reset
//   req_valid_i   segment request valid
//   seg_i         segment index
//   req_ready_o   request accepted when valid & ready at an edge
//   stall_i       datapath busy; blocks new read issue
//   flush_i       synchronous abort of the current sequence
//   mem_rd_en_o   memory read strobe
//   mem_addr_o    memory read address (0 when no read)
//   coef_valid_o  memory data valid this cycle
//   coef_idx_o    coefficient power of the current data
//   coef_last_o   current data is coefficient 0
//   done_o        one-cycle pulse when a segment is fully delivered
//   busy_o        sequencer not idle
module coeff_fetch_seq #(
    parameter int ADDR_LINES = 6,
    parameter int SEG_BITS   = 3,
    parameter int ORDER      = 3,
    parameter int MEM_LAT    = 1
) (
    input  logic                  clkn_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    input  logic [SEG_BITS-1:0]   seg_i,
    output logic                  req_ready_o,
    input  logic                  stall_i,
    input  logic                  flush_i,
    output logic                  mem_rd_en_o,
    output logic [ADDR_LINES-1:0] mem_addr_o,
    output logic                  coef_valid_o,
    output logic [((ORDER > 0) ? $clog2(ORDER + 1) : 1)-1:0] coef_idx_o,
    output logic                  coef_last_o,
    output logic                  done_o,
    output logic                  busy_o
);

    localparam int IW = (ORDER > 0) ? $clog2(ORDER + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [SEG_BITS-1:0]   seg_q, seg_d;

    logic [MEM_LAT-1:0]          tagValid_q;
    logic [MEM_LAT-1:0][IW-1:0]  tagIdx_q;
    logic [MEM_LAT-1:0]          tagLast_q;

    logic tagOutValid;
    logic tagOutLast;

    assign tagOutValid = tagValid_q[MEM_LAT-1];
    assign tagOutLast  = tagLast_q[MEM_LAT-1];

    // The address is formed modulo 2^ADDR_LINES. The parameter constraint
    // guarantees that seg*(ORDER+1)+idx never wraps, so this equals the
    // full-width sum truncated to the address width.
    always_comb begin
        mem_rd_en_o = (state_q == ISSUE) && !stall_i && !flush_i;
        mem_addr_o  = '0;
        if (mem_rd_en_o) begin
            mem_addr_o = ADDR_LINES'(seg_q) * ADDR_LINES'(ORDER + 1)
                       + ADDR_LINES'(idx_q);
        end
    end

    // req_ready_o also drops while reset is held, so nothing appears
    // acceptable until the block is actually running.
    assign req_ready_o  = (state_q == IDLE) && !flush_i && !rst_i;
    assign busy_o       = (state_q != IDLE);
    assign coef_valid_o = tagOutValid;
    assign coef_idx_o   = tagIdx_q[MEM_LAT-1];
    assign coef_last_o  = tagOutLast;
    assign done_o       = tagOutValid & tagOutLast;

    // Next-state logic. Flush overrides every other transition.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        seg_d   = seg_q;
        if (flush_i) begin
            state_d = IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        seg_d   = seg_i;
                        idx_d   = IW'(ORDER);
                        state_d = ISSUE;
                    end
                end
                ISSUE: begin
                    if (!stall_i) begin
                        if (idx_q == '0) begin
                            state_d = DRAIN;
                        end else begin
                            idx_d = idx_q - IW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (tagOutValid && tagOutLast) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clkn_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            seg_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
        end
    end

    // Tag pipe. A bubble carries idx=0 and last=0, so the tag outputs stay
    // quiet between coefficients.
    always_ff @(posedge clkn_i or posedge rst_i) begin
        if (rst_i) begin
            tagValid_q <= '0;
            tagIdx_q   <= '0;
            tagLast_q  <= '0;
        end else if (flush_i) begin
            tagValid_q <= '0;
            tagIdx_q   <= '0;
            tagLast_q  <= '0;
        end else begin
            tagValid_q[0] <= mem_rd_en_o;
            tagIdx_q[0]   <= mem_rd_en_o ? idx_q : '0;
            tagLast_q[0]  <= mem_rd_en_o && (idx_q == '0);
            for (int i = 1; i < MEM_LAT; i++) begin
                tagValid_q[i] <= tagValid_q[i-1];
                tagIdx_q[i]   <= tagIdx_q[i-1];
                tagLast_q[i]  <= tagLast_q[i-1];
            end
        end
    end

endmodule
